// File: rtl/de_stage_pkg.sv
// Shared decode-stage types: opcodes, op_class/alu_op encodings, and the FE/WB/DE latch layouts.
// agex_stage uses the same DE latch field order.
package de_stage_pkg;

  localparam int unsigned NREGS   = 32;
  localparam int unsigned REGBITS = 5;
  localparam int unsigned DBITS   = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [3:0] {
    OC_ILLEGAL = 4'd0, OC_OP, OC_OP_IMM, OC_LUI, OC_AUIPC,
    OC_JAL, OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE
  } op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [DBITS-1:0] inst;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pcplus;
    logic [DBITS-1:0] inst_count;
    logic [DBITS-1:0] pred_pc;
  } fe_latch_t;

  typedef struct packed {
    logic               we;
    logic [REGBITS-1:0] rd;
    logic [DBITS-1:0]   data;
  } wb_to_de_t;

  typedef struct packed {
    logic               valid;
    logic [DBITS-1:0]   inst;
    logic [DBITS-1:0]   pc;
    logic [DBITS-1:0]   pcplus;
    logic [DBITS-1:0]   inst_count;
    logic [DBITS-1:0]   pred_pc;
    op_class_e          op_class;
    alu_op_e            alu_op;
    logic               illegal;
    logic               is_br;
    logic               is_jmp;
    logic               wr_reg_en;
    logic [REGBITS-1:0] rd;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [DBITS-1:0]   rs1_val;
    logic [DBITS-1:0]   rs2_val;
    logic [DBITS-1:0]   imm;
  } de_latch_t;

  localparam int unsigned FE_LATCH_WIDTH        = $bits(fe_latch_t);
  localparam int unsigned FROM_WB_TO_DE_WIDTH   = $bits(wb_to_de_t);
  localparam int unsigned FROM_AGEX_TO_DE_WIDTH = 1;
  localparam int unsigned FROM_DE_TO_FE_WIDTH   = 1;
  localparam int unsigned DE_LATCH_WIDTH        = $bits(de_latch_t);

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt,
                                         input logic reg_form);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/de_regfile.sv
// 32x32 register file: one write port, two combinational read ports with WB write-through.
// x0 is never written and always reads zero.
module de_regfile
  import de_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [REGBITS-1:0] waddr_i,
  input  logic [DBITS-1:0]   wdata_i,
  input  logic [REGBITS-1:0] raddr1_i,
  input  logic [REGBITS-1:0] raddr2_i,
  output logic [DBITS-1:0]   rdata1_c_o,
  output logic [DBITS-1:0]   rdata2_c_o
);

  logic [DBITS-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-through lets a stalled consumer issue in its producer's WB cycle.
  always_comb begin
    rdata1_c_o = regs_q[raddr1_i];
    rdata2_c_o = regs_q[raddr2_i];
    if (we_i && (waddr_i == raddr1_i) && (raddr1_i != '0)) rdata1_c_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i) && (raddr2_i != '0)) rdata2_c_o = wdata_i;
  end

endmodule

// File: rtl/de_stage.sv
// Decode stage: RV32I decode, immediates, register read, scoreboard hazard detection,
// and the DE latch presented to AGEX.
module de_stage
  import de_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FE_LATCH_WIDTH-1:0]        from_FE_latch,
  input  logic [FROM_AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE,
  input  logic [FROM_WB_TO_DE_WIDTH-1:0]   from_WB_to_DE,
  output logic [FROM_DE_TO_FE_WIDTH-1:0]   from_DE_to_FE,
  output logic [DE_LATCH_WIDTH-1:0]        DE_latch_out
);

  fe_latch_t        fe;
  wb_to_de_t        wb;
  de_latch_t        dec, de_d, de_q;
  logic [NREGS-1:0] busy_d, busy_q, busy_eff;
  logic [DBITS-1:0] rs1_val, rs2_val;
  logic [DBITS-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic             mispred, uses_rs1, uses_rs2, writes_rd, hazard, issue, stall;

  assign fe      = fe_latch_t'(from_FE_latch);
  assign wb      = wb_to_de_t'(from_WB_to_DE);
  assign mispred = from_AGEX_to_DE[0];

  de_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wb.we),
    .waddr_i   (wb.rd),
    .wdata_i   (wb.data),
    .raddr1_i  (fe.inst[19:15]),
    .raddr2_i  (fe.inst[24:20]),
    .rdata1_c_o(rs1_val),
    .rdata2_c_o(rs2_val)
  );

  assign imm_i = {{20{fe.inst[31]}}, fe.inst[31:20]};
  assign imm_s = {{20{fe.inst[31]}}, fe.inst[31:25], fe.inst[11:7]};
  assign imm_b = {{19{fe.inst[31]}}, fe.inst[31], fe.inst[7], fe.inst[30:25], fe.inst[11:8], 1'b0};
  assign imm_u = {fe.inst[31:12], 12'b0};
  assign imm_j = {{11{fe.inst[31]}}, fe.inst[31], fe.inst[19:12], fe.inst[20], fe.inst[30:21], 1'b0};

  always_comb begin
    dec            = '0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    writes_rd      = 1'b0;
    dec.valid      = fe.valid;
    dec.inst       = fe.inst;
    dec.pc         = fe.pc;
    dec.pcplus     = fe.pcplus;
    dec.inst_count = fe.inst_count;
    dec.pred_pc    = fe.pred_pc;
    dec.rd         = fe.inst[11:7];
    dec.rs1        = fe.inst[19:15];
    dec.rs2        = fe.inst[24:20];
    dec.rs1_val    = rs1_val;
    dec.rs2_val    = rs2_val;
    dec.op_class   = OC_ILLEGAL;
    dec.alu_op     = ALU_ADD;
    case (fe.inst[6:0])
      OPC_OP: begin
        dec.op_class = OC_OP;
        dec.alu_op   = alu_decode(fe.inst[14:12], fe.inst[30], 1'b1);
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.op_class = OC_OP_IMM;
        dec.alu_op   = alu_decode(fe.inst[14:12], fe.inst[30], 1'b0);
        dec.imm      = imm_i;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_LUI: begin
        dec.op_class = OC_LUI;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op_class = OC_AUIPC;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_JAL: begin
        dec.op_class = OC_JAL;
        dec.imm      = imm_j;
        dec.is_jmp   = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_JALR: begin
        dec.op_class = OC_JALR;
        dec.imm      = imm_i;
        dec.is_jmp   = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.op_class = OC_BRANCH;
        dec.imm      = imm_b;
        dec.is_br    = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        dec.op_class = OC_LOAD;
        dec.imm      = imm_i;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_STORE: begin
        dec.op_class = OC_STORE;
        dec.imm      = imm_s;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.wr_reg_en = writes_rd && (dec.rd != '0);
  end

  // A register being written back this cycle is no longer a hazard.
  always_comb begin
    busy_eff = busy_q;
    if (wb.we) busy_eff[wb.rd] = 1'b0;
  end

  // rd is checked too so each register has at most one writer in flight.
  assign hazard = fe.valid && ((uses_rs1 && busy_eff[dec.rs1]) ||
                               (uses_rs2 && busy_eff[dec.rs2]) ||
                               (dec.wr_reg_en && busy_eff[dec.rd]));
  assign issue  = fe.valid && !hazard && !mispred;
  assign stall  = hazard && !mispred && !reset;

  // Clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb.we) busy_d[wb.rd] = 1'b0;
    if (mispred && de_q.valid && de_q.wr_reg_en) busy_d[de_q.rd] = 1'b0;
    if (issue && dec.wr_reg_en) busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    de_d = dec;
    if (mispred || hazard) de_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q   <= '0;
      busy_q <= '0;
    end else begin
      de_q   <= de_d;
      busy_q <= busy_d;
    end
  end

  assign from_DE_to_FE = stall;
  assign DE_latch_out  = de_q;

endmodule

// File: tb/tb_de_stage.sv
// Bench for de_stage: directed scenarios, then randomized traffic checked against a
// scoreboard/regfile reference model built from the decode-stage rules.
module tb_de_stage;
  import de_stage_pkg::*;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [FE_LATCH_WIDTH-1:0]        from_FE_latch;
  logic [FROM_AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE;
  logic [FROM_WB_TO_DE_WIDTH-1:0]   from_WB_to_DE;
  logic [FROM_DE_TO_FE_WIDTH-1:0]   from_DE_to_FE;
  logic [DE_LATCH_WIDTH-1:0]        DE_latch_out;

  fe_latch_t fe_r;
  wb_to_de_t wb_r;
  logic      mis_r;
  de_latch_t lat;

  assign from_FE_latch   = fe_r;
  assign from_WB_to_DE   = wb_r;
  assign from_AGEX_to_DE = mis_r;
  assign lat             = de_latch_t'(DE_latch_out);

  de_stage dut (
    .clk            (clk),
    .reset          (reset),
    .from_FE_latch  (from_FE_latch),
    .from_AGEX_to_DE(from_AGEX_to_DE),
    .from_WB_to_DE  (from_WB_to_DE),
    .from_DE_to_FE  (from_DE_to_FE),
    .DE_latch_out   (DE_latch_out)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rf   [32];
  logic        m_busy [32];
  de_latch_t   m_lat;
  logic        obs_stall;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fe_latch_t mk_fe(input logic v, input logic [31:0] inst);
    fe_latch_t f;
    f.valid      = v;
    f.inst       = inst;
    f.pc         = pc_ctr;
    f.pcplus     = pc_ctr + 32'd4;
    f.inst_count = pc_ctr >> 2;
    f.pred_pc    = pc_ctr + 32'd4;
    pc_ctr       = pc_ctr + 32'd4;
    return f;
  endfunction

  function automatic alu_op_e ref_alu(input logic [2:0] f3, input logic b30, input logic is_reg);
    case (f3)
      3'd0:    return (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return b30 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Immediates computed as signed sums of their bit fields.
  function automatic void ref_decode(input fe_latch_t f, output de_latch_t d,
                                     output logic u1, output logic u2);
    logic [31:0] i;
    logic        wr;
    int          v_i, v_s, v_b, v_j;
    i   = f.inst;
    v_i = int'($signed(i[31:20]));
    v_s = 32 * int'($signed(i[31:25])) + int'(i[11:7]);
    v_b = (i[31] ? -4096 : 0) + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
    v_j = (i[31] ? -1048576 : 0) + 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
    d = '0; u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
    d.valid = f.valid; d.inst = i; d.pc = f.pc; d.pcplus = f.pcplus;
    d.inst_count = f.inst_count; d.pred_pc = f.pred_pc;
    d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
    d.op_class = OC_ILLEGAL; d.alu_op = ALU_ADD;
    case (i[6:0])
      7'h33: begin d.op_class = OC_OP; u1 = 1; u2 = 1; wr = 1; d.alu_op = ref_alu(i[14:12], i[30], 1'b1); end
      7'h13: begin d.op_class = OC_OP_IMM; u1 = 1; wr = 1; d.imm = 32'(v_i); d.alu_op = ref_alu(i[14:12], i[30], 1'b0); end
      7'h37: begin d.op_class = OC_LUI; wr = 1; d.imm = i & 32'hFFFFF000; end
      7'h17: begin d.op_class = OC_AUIPC; wr = 1; d.imm = i & 32'hFFFFF000; end
      7'h6F: begin d.op_class = OC_JAL; wr = 1; d.is_jmp = 1; d.imm = 32'(v_j); end
      7'h67: begin d.op_class = OC_JALR; u1 = 1; wr = 1; d.is_jmp = 1; d.imm = 32'(v_i); end
      7'h63: begin d.op_class = OC_BRANCH; u1 = 1; u2 = 1; d.is_br = 1; d.imm = 32'(v_b); end
      7'h03: begin d.op_class = OC_LOAD; u1 = 1; wr = 1; d.imm = 32'(v_i); end
      7'h23: begin d.op_class = OC_STORE; u1 = 1; u2 = 1; d.imm = 32'(v_s); end
      default: d.illegal = 1'b1;
    endcase
    d.wr_reg_en = wr && (d.rd != 5'd0);
  endfunction

  function automatic logic beff(input logic [4:0] r);
    return m_busy[r] && !(wb_r.we && wb_r.rd == r);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_r.we && wb_r.rd == r) return wb_r.data;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin m_rf[k] = '0; m_busy[k] = 1'b0; end
    m_lat = '0;
  endtask

  // One clock: check stall against the model, advance model and DUT, check the DE latch.
  task automatic cycle();
    de_latch_t d;
    logic      u1, u2, hz, iss, exp_stall;
    #1;
    ref_decode(fe_r, d, u1, u2);
    hz = fe_r.valid && ((u1 && beff(d.rs1)) || (u2 && beff(d.rs2)) || (d.wr_reg_en && beff(d.rd)));
    exp_stall = hz && !mis_r;
    obs_stall = from_DE_to_FE[0];
    check("stall", 300'(obs_stall), 300'(exp_stall));
    d.rs1_val = rf_read(d.rs1);
    d.rs2_val = rf_read(d.rs2);
    iss = fe_r.valid && !hz && !mis_r;
    if (mis_r) begin
      if (m_lat.valid && m_lat.wr_reg_en) m_busy[m_lat.rd] = 1'b0;
      m_lat = '0;
    end else if (hz) m_lat = '0;
    else m_lat = d;
    if (wb_r.we) begin
      m_busy[wb_r.rd] = 1'b0;
      if (wb_r.rd != 5'd0) m_rf[wb_r.rd] = wb_r.data;
    end
    if (iss && d.wr_reg_en) m_busy[d.rd] = 1'b1;
    @(posedge clk); #1;
    check("de_latch", 300'(DE_latch_out), 300'(m_lat));
  endtask

  task automatic idle_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_r.we = we; wb_r.rd = rd; wb_r.data = data;
  endtask

  initial begin
    logic [31:0] inst;
    int          s, r;
    reset = 1'b1; fe_r = '0; mis_r = 1'b0; wb_r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 300'(lat.valid), 300'(1'b0));
    check("reset_stall", 300'(from_DE_to_FE[0]), 300'(1'b0));
    reset = 1'b0;

    // addi x1,x0,-1, then retire x1 with 0x55
    fe_r = mk_fe(1'b1, 32'hFFF00093);
    cycle();
    check("addi_imm", 300'(lat.imm), 300'(32'hFFFFFFFF));
    check("addi_rd", 300'(lat.rd), 300'(5'd1));
    check("addi_wr_en", 300'(lat.wr_reg_en), 300'(1'b1));
    fe_r = mk_fe(1'b0, 32'h0); idle_wb(1'b1, 5'd1, 32'h55);
    cycle();

    // jal x0,+8 alongside an unrelated x5 write
    fe_r = mk_fe(1'b1, 32'h0080006F); idle_wb(1'b1, 5'd5, 32'hABCD);
    cycle();
    check("jal_is_jmp", 300'(lat.is_jmp), 300'(1'b1));
    check("jal_imm", 300'(lat.imm), 300'(32'd8));
    check("jal_wr_en", 300'(lat.wr_reg_en), 300'(1'b0));

    fe_r = mk_fe(1'b1, 32'h00000000); idle_wb(1'b0, 5'd0, 32'h0);
    cycle();
    check("illegal_flag", 300'(lat.illegal), 300'(1'b1));
    check("illegal_wr_en", 300'(lat.wr_reg_en), 300'(1'b0));

    // RAW: add x3,x1,x2 then sub x4,x3,x1
    fe_r = mk_fe(1'b1, 32'h002081B3);
    cycle();
    fe_r = mk_fe(1'b1, 32'h40118233);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("raw_stall", 300'(obs_stall), 300'(1'b1));
      check("raw_bubble", 300'(lat.valid), 300'(1'b0));
    end
    idle_wb(1'b1, 5'd3, 32'h1234);
    cycle();
    check("raw_release", 300'(obs_stall), 300'(1'b0));
    check("raw_rs1_val", 300'(lat.rs1_val), 300'(32'h1234));
    check("raw_rs2_val", 300'(lat.rs2_val), 300'(32'h55));
    fe_r = mk_fe(1'b0, 32'h0); idle_wb(1'b0, 5'd0, 32'h0);
    cycle();

    // WAW on x7
    fe_r = mk_fe(1'b1, 32'h00100393);
    cycle();
    fe_r = mk_fe(1'b1, 32'h00200393);
    cycle();
    check("waw_stall", 300'(obs_stall), 300'(1'b1));
    idle_wb(1'b1, 5'd7, 32'h1);
    cycle();
    check("waw_issue", 300'(obs_stall), 300'(1'b0));
    check("waw_valid", 300'(lat.valid), 300'(1'b1));
    fe_r = mk_fe(1'b0, 32'h0); idle_wb(1'b1, 5'd7, 32'h2);
    cycle();
    idle_wb(1'b0, 5'd0, 32'h0);

    // Back-to-back writes to x0
    for (int k = 0; k < 2; k++) begin
      fe_r = mk_fe(1'b1, 32'h00508013);
      cycle();
      check("x0_nostall", 300'(obs_stall), 300'(1'b0));
      check("x0_wr_en", 300'(lat.wr_reg_en), 300'(1'b0));
    end

    // Flush: lw x9 in the DE latch, consumer of x9 waiting in FE
    fe_r = mk_fe(1'b1, 32'h0000A483);
    cycle();
    fe_r = mk_fe(1'b1, 32'h00048533); mis_r = 1'b1;
    cycle();
    check("flush_nostall", 300'(obs_stall), 300'(1'b0));
    check("flush_bubble", 300'(lat.valid), 300'(1'b0));
    mis_r = 1'b0;
    cycle();
    check("post_flush_issue", 300'(obs_stall), 300'(1'b0));
    check("post_flush_rd", 300'(lat.rd), 300'(5'd10));

    // Mid-cycle reset with x10 busy: add x11,x10,x4
    fe_r = mk_fe(1'b1, 32'h004505B3);
    #1;
    check("pre_reset_stall", 300'(from_DE_to_FE[0]), 300'(1'b1));
    #1 reset = 1'b1;
    #1;
    check("midreset_valid", 300'(lat.valid), 300'(1'b0));
    check("midreset_stall", 300'(from_DE_to_FE[0]), 300'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle();
    check("post_reset_nostall", 300'(obs_stall), 300'(1'b0));
    fe_r = mk_fe(1'b1, 32'h00528333);
    cycle();
    check("x5_after_reset", 300'(lat.rs1_val), 300'(32'h0));

    // Randomized traffic; FE holds its instruction while stalled
    for (int n = 0; n < 600; n++) begin
      if (!obs_stall || mis_r) begin
        case ($urandom_range(0, 9))
          0: inst = {25'($urandom), 7'h33};
          1: inst = {25'($urandom), 7'h13};
          2: inst = {25'($urandom), 7'h37};
          3: inst = {25'($urandom), 7'h17};
          4: inst = {25'($urandom), 7'h6F};
          5: inst = {25'($urandom), 7'h67};
          6: inst = {25'($urandom), 7'h63};
          7: inst = {25'($urandom), 7'h03};
          8: inst = {25'($urandom), 7'h23};
          default: inst = $urandom;
        endcase
        inst[11:7]  = 5'($urandom_range(0, 7));
        inst[19:15] = 5'($urandom_range(0, 7));
        inst[24:20] = 5'($urandom_range(0, 7));
        fe_r = mk_fe($urandom_range(0, 9) < 8, inst);
      end
      mis_r = ($urandom_range(0, 99) < 8);
      wb_r = '0;
      if ($urandom_range(0, 9) < 4) begin
        s = $urandom_range(1, 31);
        for (int j = 0; j < 31; j++) begin
          r = 1 + (s - 1 + j) % 31;
          if (m_busy[r] && !wb_r.we) begin
            wb_r.we = 1'b1; wb_r.rd = 5'(r); wb_r.data = $urandom;
          end
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
